vjtag_mem_bridge: RTL and testbench
===================================

Name: vjtag_mem_bridge

Overview:
Parametrised virtual-JTAG-to-memory bridge that generalises the single-byte JTAG memory access path.
- Separate address and data scan chains, with address and data widths set by parameters.
- Burst reads and writes with address auto-increment.
- Read prefetch through a request/valid handshake, so memory latency can vary.
- Sits between the virtual-JTAG hub outputs and an on-chip RAM. All logic runs in the tck domain.

Parameters:
ADDR_W, 16, memory address width and ADDR scan chain length
DATA_W, 8, memory data width; WDATA chain length is DATA_W, RDATA chain length is DATA_W+1
AUTO_INC, 1, 1 = increment the address after each write and each read issue; 0 = fixed address

Ports:
tck  input  1  JTAG clock; the only clock
aclr  input  1  asynchronous active-low reset
tdi  input  1  serial data in
ir_in  input  2  instruction: 00 BYPASS, 01 ADDR, 10 WDATA, 11 RDATA
v_sdr  input  1  shift-DR strobe
v_cdr  input  1  capture-DR strobe
v_udr  input  1  update-DR strobe
v_uir  input  1  update-IR strobe; ir_in is valid with it
tdo  output  1  serial data out, LSB of the selected DR
mem_we  output  1  one-cycle write strobe
mem_re  output  1  one-cycle read request
mem_addr  output  ADDR_W  address for mem_we/mem_re, same cycle
mem_wdata  output  DATA_W  write data
mem_rdata  input  DATA_W  read data, sampled when mem_rvalid=1
mem_rvalid  input  1  read response, one cycle, ≥1 cycle after mem_re
busy  output  1  read outstanding

Behaviour:
- Reset (aclr=0, async): all DRs 0, addr_q 0, rd_buf 0, rd_valid 0, pending 0, drop 0, underrun 0. mem_we, mem_re, busy and tdo are 0.
- Shifting: on v_sdr, the selected DR does DR <= {tdi, DR[W-1:1]}.
  - BYPASS DR is 1 bit.
  - tdo is combinational: the LSB of the DR selected by ir_in.
- ADDR:
  - v_cdr: DR <= addr_q.
  - v_udr: addr_q <= DR, and rd_valid <= 0. If a read is pending, set drop <= 1.
- WDATA:
  - v_cdr: DR <= 0.
  - v_udr: mem_we=1 for exactly that cycle, with mem_addr=addr_q and mem_wdata=DR. Next cycle, addr_q += AUTO_INC.
- RDATA:
  - v_cdr: DR <= {rd_valid, rd_buf}, so bit 0 shifts out first and the valid flag shifts out last. Then:
    - If rd_valid=0, set underrun <= 1 (sticky until reset).
    - Clear rd_valid.
    - If pending=0, issue a read this cycle.
  - v_uir with ir_in=RDATA: issue a read if rd_valid=0 and pending=0 (prefetch).
- Read issue:
  - mem_re=1 for one cycle, with mem_addr=addr_q. Next cycle, addr_q += AUTO_INC and pending <= 1.
  - Maximum one read outstanding. Further issue requests while pending=1 are ignored; the v_cdr-triggered re-issue is skipped.
- Read response: on mem_rvalid with pending=1, pending <= 0.
  - drop=0: rd_buf <= mem_rdata, rd_valid <= 1.
  - drop=1: data is discarded and drop <= 0.
  - mem_rvalid with pending=0 is ignored.
- mem_addr: equals addr_q whenever neither strobe is active.
- busy: equals pending.
- Address wrap: all-ones increments to 0. No flag is raised.
- Simultaneous events:
  - mem_rvalid and an RDATA v_cdr in the same cycle: the capture sees the old rd_valid/rd_buf. The new data then lands in rd_buf with rd_valid=1. No re-issue happens that cycle, because pending is still 1.
  - mem_we and a pending read are independent. A write to the address of an in-flight read does not update rd_buf.
- Reset mid-operation: a pending read is forgotten. A later stray mem_rvalid is ignored.
- underrun: internal, with no port. RDATA bit DATA_W reports valid per word.

Test Plan:
- Reset: assert aclr=0 mid-shift. Required: all outputs 0, addr_q=0, and a subsequent ADDR capture shifts out 16 zeros.
- Address load: scan 0x1234 into ADDR and pulse v_udr, then ADDR capture/shift. Required: tdo sequence is 0x1234 LSB-first; no mem_we or mem_re.
- Burst write: ADDR=0x00FE, then WDATA 0xA5, 0x5A, 0x3C. Required: three single-cycle mem_we at 0x00FE, 0x00FF, 0x0100 with the matching data.
- Burst read with latency 3:
  - Stimulus: ADDR=0x0010, RDATA v_uir, then capture/shift three times; memory returns 0x11, 0x22, 0x33.
  - Required: mem_re issues at 0x0010, 0x0011, 0x0012 and 0x0013 (the last is the prefetch after the third capture). Shifted words are {1,0x11}, {1,0x22}, {1,0x33}.
- Underrun/drop:
  - Stimulus: latency 10 and capture immediately. Next, reload ADDR while a read is pending.
  - Required: the first word shows valid bit 0. The response after the reload is discarded, and rd_valid stays 0.
- Wrap and BYPASS:
  - Stimulus: ADDR=0xFFFF, then one WDATA write. Separately, shift 1,0,1 through BYPASS.
  - Required: the write is at 0xFFFF and the next ADDR capture reads 0x0000. BYPASS tdo follows tdi delayed by one tck.

Source files
------------

// File: rtl/vjtag_mem_bridge.sv
// Virtual-JTAG to on-chip RAM bridge.
// Separate ADDR / WDATA / RDATA scan chains, burst access with optional
// address auto-increment, and a single-entry read prefetch that tolerates
// variable memory latency through a request/valid handshake.
// Everything runs on tck.
//
// Memory handshake: mem_we and mem_re are single-cycle strobes qualified by
// mem_addr (and mem_wdata for writes) in the same cycle. At most one read is
// outstanding; the memory answers it with a single-cycle mem_rvalid carrying
// mem_rdata at least one cycle after mem_re. busy is high from the cycle after
// mem_re until the cycle mem_rvalid is accepted.
module vjtag_mem_bridge #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              tck,
  input  logic              aclr,
  input  logic              tdi,
  input  logic [1:0]        ir_in,
  input  logic              v_sdr,
  input  logic              v_cdr,
  input  logic              v_udr,
  input  logic              v_uir,
  output logic              tdo,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  localparam logic [1:0] IR_BYPASS = 2'b00;
  localparam logic [1:0] IR_ADDR   = 2'b01;
  localparam logic [1:0] IR_WDATA  = 2'b10;
  localparam logic [1:0] IR_RDATA  = 2'b11;

  // Step applied to the address after each write and each read issue.
  localparam logic [ADDR_W-1:0] LP_INC = ADDR_W'(AUTO_INC != 0);

  // Data registers
  logic              r_bypass;
  logic [ADDR_W-1:0] r_addr_dr;
  logic [DATA_W-1:0] r_wdata_dr;
  logic [DATA_W:0]   r_rdata_dr;

  // Access state
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_rd_buf;
  logic              r_rd_valid;
  logic              r_pending;
  logic              r_drop;
  logic              r_underrun;

  // Decoded strobes
  logic w_sel_bypass;
  logic w_sel_addr;
  logic w_sel_wdata;
  logic w_sel_rdata;
  logic w_addr_upd;
  logic w_wr;
  logic w_rd_cap;
  logic w_prefetch;
  logic w_issue;
  logic w_resp;

  assign w_sel_bypass = (ir_in == IR_BYPASS);
  assign w_sel_addr   = (ir_in == IR_ADDR);
  assign w_sel_wdata  = (ir_in == IR_WDATA);
  assign w_sel_rdata  = (ir_in == IR_RDATA);

  assign w_addr_upd = v_udr & w_sel_addr;
  assign w_wr       = v_udr & w_sel_wdata;
  assign w_rd_cap   = v_cdr & w_sel_rdata;
  // Prefetch on entering RDATA only if there is nothing buffered yet.
  assign w_prefetch = v_uir & w_sel_rdata & ~r_rd_valid;
  // A capture always tries to refill; only one read may be in flight.
  assign w_issue    = (w_rd_cap | w_prefetch) & ~r_pending;
  // Responses without an outstanding read are stray and ignored.
  assign w_resp     = mem_rvalid & r_pending;

  // Scan chains: capture, shift towards bit 0, one chain per instruction.
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_bypass   <= 1'b0;
      r_addr_dr  <= '0;
      r_wdata_dr <= '0;
      r_rdata_dr <= '0;
    end else begin
      if (w_sel_bypass) begin
        if (v_cdr)      r_bypass <= 1'b0;
        else if (v_sdr) r_bypass <= tdi;
      end
      if (w_sel_addr) begin
        if (v_cdr)      r_addr_dr <= r_addr_q;
        else if (v_sdr) r_addr_dr <= {tdi, r_addr_dr[ADDR_W-1:1]};
      end
      if (w_sel_wdata) begin
        if (v_cdr)      r_wdata_dr <= '0;
        else if (v_sdr) r_wdata_dr <= {tdi, r_wdata_dr[DATA_W-1:1]};
      end
      if (w_sel_rdata) begin
        if (v_cdr)      r_rdata_dr <= {r_rd_valid, r_rd_buf};
        else if (v_sdr) r_rdata_dr <= {tdi, r_rdata_dr[DATA_W:1]};
      end
    end
  end

  // Address register: loaded from the ADDR chain, stepped after each access.
  // Load, write and read issue need different instructions, so they never collide.
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_addr_q <= '0;
    end else if (w_addr_upd) begin
      r_addr_q <= r_addr_dr;
    end else if (w_wr || w_issue) begin
      r_addr_q <= r_addr_q + LP_INC;
    end
  end

  // Read tracking: outstanding flag, discard-after-reload flag, read buffer.
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_pending  <= 1'b0;
      r_drop     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_buf   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_issue)     r_pending <= 1'b1;
      else if (w_resp) r_pending <= 1'b0;

      // A response consumes any pending discard; a reload while a read is
      // in flight marks that read's data as stale.
      if (w_resp)                       r_drop <= 1'b0;
      else if (w_addr_upd && r_pending) r_drop <= 1'b1;

      // A response landing in the same cycle as a reload is also stale.
      // Otherwise fresh data wins over a capture clearing the buffer.
      if (w_resp && !r_drop && !w_addr_upd) begin
        r_rd_buf   <= mem_rdata;
        r_rd_valid <= 1'b1;
      end else if (w_addr_upd || w_rd_cap) begin
        r_rd_valid <= 1'b0;
      end

      // Sticky record that the host read a word before it had arrived.
      if (w_rd_cap && !r_rd_valid) r_underrun <= 1'b1;
    end
  end

  // The underrun flag has no port; it is kept for probing by hierarchical name.
  logic w_unused_underrun;
  assign w_unused_underrun = r_underrun;

  // Serial output: LSB of the chain selected by the current instruction.
  always_comb begin
    tdo = 1'b0;
    case (ir_in)
      IR_BYPASS: tdo = r_bypass;
      IR_ADDR:   tdo = r_addr_dr[0];
      IR_WDATA:  tdo = r_wdata_dr[0];
      IR_RDATA:  tdo = r_rdata_dr[0];
      default:   tdo = 1'b0;
    endcase
  end

  assign mem_we    = w_wr;
  assign mem_re    = w_issue;
  assign mem_addr  = r_addr_q;
  assign mem_wdata = r_wdata_dr;
  assign busy      = r_pending;

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// Directed bench for vjtag_mem_bridge with a variable-latency memory responder.
module tb_vjtag_mem_bridge;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [1:0] IR_BYPASS = 2'b00;
  localparam logic [1:0] IR_ADDR   = 2'b01;
  localparam logic [1:0] IR_WDATA  = 2'b10;
  localparam logic [1:0] IR_RDATA  = 2'b11;

  logic              tck;
  logic              aclr;
  logic              tdi;
  logic [1:0]        ir_in;
  logic              v_sdr;
  logic              v_cdr;
  logic              v_udr;
  logic              v_uir;
  logic              tdo;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int lat      = 3;

  logic [7:0]               tb_mem [256];
  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [ADDR_W-1:0]        re_q[$];
  logic [ADDR_W-1:0]        exp_q[$];

  vjtag_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_INC(1)) dut (
    .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in),
    .v_sdr(v_sdr), .v_cdr(v_cdr), .v_udr(v_udr), .v_uir(v_uir),
    .tdo(tdo), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy)
  );

  // clock / watchdog
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory responder: answers each mem_re after lat cycles
  initial begin
    int cnt;
    logic [ADDR_W-1:0] a;
    cnt = 0;
    a = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge tck);
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = tb_mem[a[7:0]];
        end
      end
      if (aclr && mem_re) begin
        a = mem_addr;
        cnt = lat;
      end
    end
  end

  // strobe monitor
  always @(negedge tck) begin
    if (aclr && mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (aclr && mem_re) re_q.push_back(mem_addr);
  end

  // driver tasks
  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      v_sdr = 1'b1;
      dout[i] = tdo;
      step();
    end
    v_sdr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic scan(input logic [1:0] ir, input logic [31:0] din, input int n,
                      output logic [31:0] dout);
    ir_in = ir;
    v_cdr = 1'b1;
    step();
    v_cdr = 1'b0;
    shift_bits(din, n, dout);
    v_udr = 1'b1;
    step();
    v_udr = 1'b0;
  endtask

  task automatic set_ir(input logic [1:0] ir);
    ir_in = ir;
    v_uir = 1'b1;
    step();
    v_uir = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b required 0", tag, busy);
    end
    step();
    step();
  endtask

  // tests
  task automatic test_reset();
    logic [31:0] d;
    // still in reset from time zero
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL rst_tdo: got %b required 0", tdo); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b required 0", mem_we); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rst_re: got %b required 0", mem_re); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr: got %h required 0000", mem_addr); end
    aclr = 1'b1;
    step();
    // put a read in flight, then reset in the middle of an ADDR shift
    scan(IR_ADDR, 32'h00AB, 16, d);
    lat = 12;
    ir_in = IR_RDATA;
    v_uir = 1'b1;
    #1;
    checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h00AB) begin
      failures++; $display("FAIL rst_prefetch: re=%b addr=%h required re=1 addr=00ab", mem_re, mem_addr);
    end
    step();
    v_uir = 1'b0;
    ir_in = IR_ADDR;
    v_cdr = 1'b1;
    step();
    v_cdr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tdi = 1'b1;
      v_sdr = 1'b1;
      step();
    end
    #2;
    aclr = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL midrst_addr: got %h required 0000", mem_addr); end
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL midrst_tdo: got %b required 0", tdo); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      failures++; $display("FAIL midrst_strobes: we=%b re=%b required 0 0", mem_we, mem_re);
    end
    v_sdr = 1'b0;
    tdi = 1'b0;
    step();
    step();
    aclr = 1'b1;
    // the stray response to the forgotten read arrives during this idle time
    repeat (14) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy: got %b required 0", busy); end
    re_q.delete();
    scan(IR_ADDR, 32'h0, 16, d);
    checks++; if (d[15:0] !== 16'h0000) begin failures++; $display("FAIL rst_addr_scan: got %h required 0000", d[15:0]); end
    lat = 3;
    scan(IR_RDATA, 32'h0, 9, d);
    checks++; if (d[8:0] !== 9'h000) begin failures++; $display("FAIL stray_rdata: got %h required 000", d[8:0]); end
    checks++; if (re_q.size() != 1 || re_q[0] !== 16'h0000) begin
      failures++; $display("FAIL rst_reissue: count=%0d required 1 at 0000", re_q.size());
    end
    wait_idle("reset");
  endtask

  task automatic test_addr_load();
    logic [31:0] d;
    wr_q.delete();
    re_q.delete();
    scan(IR_ADDR, 32'h1234, 16, d);
    checks++; if (mem_addr !== 16'h1234) begin failures++; $display("FAIL addr_mem_addr: got %h required 1234", mem_addr); end
    scan(IR_ADDR, 32'h1234, 16, d);
    checks++; if (d[15:0] !== 16'h1234) begin failures++; $display("FAIL addr_readback: got %h required 1234", d[15:0]); end
    checks++; if (wr_q.size() != 0 || re_q.size() != 0) begin
      failures++; $display("FAIL addr_no_access: writes=%0d reads=%0d required 0 0", wr_q.size(), re_q.size());
    end
  endtask

  task automatic test_burst_write();
    logic [31:0] d;
    logic [23:0] exp_w [3];
    exp_w[0] = {16'h00FE, 8'hA5};
    exp_w[1] = {16'h00FF, 8'h5A};
    exp_w[2] = {16'h0100, 8'h3C};
    scan(IR_ADDR, 32'h00FE, 16, d);
    wr_q.delete();
    re_q.delete();
    scan(IR_WDATA, 32'hA5, 8, d);
    checks++; if (d[7:0] !== 8'h00) begin failures++; $display("FAIL wdata_capture: got %h required 00", d[7:0]); end
    scan(IR_WDATA, 32'h5A, 8, d);
    scan(IR_WDATA, 32'h3C, 8, d);
    checks++; if (wr_q.size() != 3) begin failures++; $display("FAIL wr_count: got %0d required 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin
          failures++; $display("FAIL wr_%0d: got %h required %h", i, wr_q[i], exp_w[i]);
        end
      end
    end
    checks++; if (mem_addr !== 16'h0101) begin failures++; $display("FAIL wr_next_addr: got %h required 0101", mem_addr); end
    checks++; if (re_q.size() != 0) begin failures++; $display("FAIL wr_no_read: got %0d required 0", re_q.size()); end
  endtask

  task automatic test_burst_read();
    logic [31:0] d;
    logic [8:0] exp_word [3];
    exp_word[0] = 9'h111;
    exp_word[1] = 9'h122;
    exp_word[2] = 9'h133;
    lat = 3;
    scan(IR_ADDR, 32'h0010, 16, d);
    re_q.delete();
    exp_q.delete();
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h0013);
    set_ir(IR_RDATA);
    wait_idle("prefetch");
    for (int k = 0; k < 3; k++) begin
      scan(IR_RDATA, 32'h0, 9, d);
      checks++;
      if (d[8:0] !== exp_word[k]) begin
        failures++; $display("FAIL rd_word_%0d: got %h required %h", k, d[8:0], exp_word[k]);
      end
    end
    wait_idle("burst_read");
    checks++; if (re_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rd_issue_count: got %0d required %0d", re_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && re_q.size() > 0) begin
      checks++;
      if (re_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL rd_issue_addr: got %h required %h", re_q[0], exp_q[0]);
      end
      void'(re_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_underrun_drop();
    logic [31:0] d;
    // buffer holds 0x44 from the prefetch of 0x0013; reload clears its valid bit
    scan(IR_ADDR, 32'h0020, 16, d);
    re_q.delete();
    lat = 12;
    scan(IR_RDATA, 32'h0, 9, d);
    checks++; if (d[8:0] !== 9'h044) begin failures++; $display("FAIL underrun_word: got %h required 044", d[8:0]); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL underrun_pending: busy=%b required 1", busy); end
    // reload the address (DR still holds 0x0020) while that read is in flight
    ir_in = IR_ADDR;
    v_udr = 1'b1;
    step();
    v_udr = 1'b0;
    wait_idle("drop");
    lat = 3;
    scan(IR_RDATA, 32'h0, 9, d);
    checks++; if (d[8:0] !== 9'h044) begin failures++; $display("FAIL drop_word: got %h required 044", d[8:0]); end
    checks++; if (re_q.size() != 2 || re_q[0] !== 16'h0020 || re_q[1] !== 16'h0020) begin
      failures++; $display("FAIL drop_issues: count=%0d required 2 reads at 0020", re_q.size());
    end
    wait_idle("drop_end");
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    scan(IR_ADDR, 32'hFFFF, 16, d);
    wr_q.delete();
    scan(IR_WDATA, 32'h77, 8, d);
    checks++; if (wr_q.size() != 1 || wr_q[0] !== {16'hFFFF, 8'h77}) begin
      failures++; $display("FAIL wrap_write: count=%0d required 1 write of 77 at ffff", wr_q.size());
    end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_mem_addr: got %h required 0000", mem_addr); end
    scan(IR_ADDR, 32'h0, 16, d);
    checks++; if (d[15:0] !== 16'h0000) begin failures++; $display("FAIL wrap_capture: got %h required 0000", d[15:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    ir_in = IR_BYPASS;
    v_cdr = 1'b1;
    step();
    v_cdr = 1'b0;
    shift_bits(32'h5, 3, d);
    checks++; if (d[2:0] !== 3'b010) begin failures++; $display("FAIL bypass_seq: got %b required 010", d[2:0]); end
    checks++; if (tdo !== 1'b1) begin failures++; $display("FAIL bypass_last: got %b required 1", tdo); end
  endtask

  // main sequence
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    tb_mem[8'h10] = 8'h11;
    tb_mem[8'h11] = 8'h22;
    tb_mem[8'h12] = 8'h33;
    tb_mem[8'h13] = 8'h44;
    aclr  = 1'b0;
    tdi   = 1'b0;
    ir_in = IR_BYPASS;
    v_sdr = 1'b0;
    v_cdr = 1'b0;
    v_udr = 1'b0;
    v_uir = 1'b0;
    step();
    step();
    test_reset();
    test_addr_load();
    test_burst_write();
    test_burst_read();
    test_underrun_drop();
    test_wrap();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
